// File: rtl/writeback_arbiter_if.sv
// Multi-cycle result channel into the write-back arbiter: valid/ready
// handshake carrying the destination register and result data.
interface writeback_arbiter_if #(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 5
);
    logic                 mc_valid;
    logic                 mc_ready;
    logic [ADD_WIDTH-1:0] mc_rd;
    logic [WIDTH-1:0]     mc_data;

    // producer side (multi-cycle execution unit / load miss path)
    modport master (
        output mc_valid,
        output mc_rd,
        output mc_data,
        input  mc_ready
    );

    // consumer side (arbiter)
    modport slave (
        input  mc_valid,
        input  mc_rd,
        input  mc_data,
        output mc_ready
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges pipeline results and buffered multi-cycle
// results onto the single register-file write port, tracks pending
// destinations in a busy scoreboard and asks the pipeline to stall when
// buffered results have been starved for too long.
module writeback_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADD_WIDTH  = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pipe_valid,
    input  logic [ADD_WIDTH-1:0]    pipe_rd,
    input  logic [WIDTH-1:0]        pipe_data,
    writeback_arbiter_if.slave      mc,
    input  logic                    issue_valid,
    input  logic [ADD_WIDTH-1:0]    issue_rd,
    output logic [2**ADD_WIDTH-1:0] busy,
    output logic                    stall_req,
    output logic                    rf_write_enable,
    output logic [ADD_WIDTH-1:0]    rf_address,
    output logic [WIDTH-1:0]        rf_write_data,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam int NREG  = 2**ADD_WIDTH;

    logic [ADD_WIDTH-1:0] rd_mem   [DEPTH];
    logic [WIDTH-1:0]     data_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [ST_W-1:0]      starve_q;

    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 pipe_grant;
    logic [CNT_W-1:0]     count_nxt;
    logic [ST_W-1:0]      starve_nxt;
    logic [NREG-1:0]      busy_nxt;
    logic [ADD_WIDTH-1:0] head_rd;
    logic [WIDTH-1:0]     head_data;

    assign empty       = (fifo_count == '0);
    assign full        = (fifo_count == CNT_W'(DEPTH));
    assign mc.mc_ready = !full;
    assign push        = mc.mc_valid && !full && (mc.mc_rd != '0);
    assign head_rd     = rd_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];

    // grant selection: stall forces the FIFO, else pipeline first, else FIFO
    always_comb begin
        pipe_grant = 1'b0;
        pop        = 1'b0;
        if (stall_req) begin
            pop = !empty;
        end else if (pipe_valid && (pipe_rd != '0)) begin
            pipe_grant = 1'b1;
        end else begin
            pop = !empty;
        end
    end

    // next occupancy, starvation count and scoreboard
    always_comb begin
        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + CNT_W'(1);
            2'b01:   count_nxt = fifo_count - CNT_W'(1);
            default: count_nxt = fifo_count;
        endcase

        starve_nxt = starve_q;
        if (empty || pop) begin
            starve_nxt = '0;
        end else if (pipe_grant && (starve_q != ST_W'(STARVE_MAX))) begin
            starve_nxt = starve_q + ST_W'(1);
        end

        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // FIFO storage needs no reset; occupancy/pointers guard its contents
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= mc.mc_rd;
            data_mem[wr_ptr] <= mc.mc_data;
        end
    end

    // control state and registered register-file write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            starve_q        <= '0;
            stall_req       <= 1'b0;
            busy            <= '0;
            rf_write_enable <= 1'b0;
            rf_address      <= '0;
            rf_write_data   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_nxt;
            starve_q   <= starve_nxt;
            // built from next-state values so stall_req always mirrors the
            // live counter and occupancy rather than lagging them by a cycle
            stall_req  <= (starve_nxt == ST_W'(STARVE_MAX)) && (count_nxt != '0);
            busy       <= busy_nxt;
            rf_write_enable <= pipe_grant || pop;
            if (pipe_grant) begin
                rf_address    <= pipe_rd;
                rf_write_data <= pipe_data;
            end else if (pop) begin
                rf_address    <= head_rd;
                rf_write_data <= head_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        stall_req;
    logic        rf_write_enable;
    logic [4:0]  rf_address;
    logic [31:0] rf_write_data;
    logic [2:0]  fifo_count;

    int unsigned checks;
    int unsigned errors;

    writeback_arbiter_if #(.WIDTH(32), .ADD_WIDTH(5)) mc_if ();

    writeback_arbiter #(
        .WIDTH(32),
        .ADD_WIDTH(5),
        .DEPTH(4),
        .STARVE_MAX(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pipe_valid(pipe_valid),
        .pipe_rd(pipe_rd),
        .pipe_data(pipe_data),
        .mc(mc_if.slave),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .busy(busy),
        .stall_req(stall_req),
        .rf_write_enable(rf_write_enable),
        .rf_address(rf_address),
        .rf_write_data(rf_write_data),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid     = 1'b0;
        pipe_rd        = '0;
        pipe_data      = '0;
        issue_valid    = 1'b0;
        issue_rd       = '0;
        mc_if.mc_valid = 1'b0;
        mc_if.mc_rd    = '0;
        mc_if.mc_data  = '0;
    endtask

    task automatic mc_push(input logic [4:0] rd, input logic [31:0] data);
        mc_if.mc_valid = 1'b1;
        mc_if.mc_rd    = rd;
        mc_if.mc_data  = data;
    endtask

    task automatic pipe_drive(input logic [4:0] rd, input logic [31:0] data);
        pipe_valid = 1'b1;
        pipe_rd    = rd;
        pipe_data  = data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_req, 0);
        check("rst_we", rf_write_enable, 0);
        check("rst_addr", rf_address, 0);
        check("rst_data", rf_write_data, 0);
        check("rst_ready", mc_if.mc_ready, 1);
        reset = 1'b1;

        // pipeline-only write
        pipe_drive(5'd5, 32'hDEADBEEF);
        step();
        check("pipe_we", rf_write_enable, 1);
        check("pipe_addr", rf_address, 5);
        check("pipe_data", rf_write_data, 32'hDEADBEEF);
        check("pipe_busy", busy, 0);
        idle();
        step();
        check("idle_we", rf_write_enable, 0);
        check("idle_addr_hold", rf_address, 5);
        check("idle_data_hold", rf_write_data, 32'hDEADBEEF);

        // issue then drain
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        idle();
        check("issue_busy7", busy, 32'h0000_0080);
        mc_push(5'd7, 32'h12345678);
        step();
        idle();
        check("drain_count1", fifo_count, 1);
        check("drain_busy_pending", busy, 32'h0000_0080);
        check("drain_we_none", rf_write_enable, 0);
        step();
        check("drain_we", rf_write_enable, 1);
        check("drain_addr", rf_address, 7);
        check("drain_data", rf_write_data, 32'h12345678);
        check("drain_busy_clr", busy, 0);
        check("drain_count0", fifo_count, 0);

        // fill the FIFO while the pipeline keeps winning
        for (int unsigned i = 0; i < 4; i++) begin
            pipe_drive(5'(1 + i), 32'h100 + i);
            mc_push(5'(10 + i), 32'hA0 + i);
            step();
            check("full_pipe_addr", rf_address, 1 + i);
            check("full_count", fifo_count, i + 1);
            check("full_stall", stall_req, (i == 3) ? 1 : 0);
        end
        check("full_ready", mc_if.mc_ready, 0);
        mc_if.mc_valid = 1'b0;
        pipe_drive(5'd2, 32'h555);
        step();
        check("stall_fifo_we", rf_write_enable, 1);
        check("stall_fifo_addr", rf_address, 10);
        check("stall_fifo_data", rf_write_data, 32'hA0);
        check("stall_drop", stall_req, 0);
        check("stall_count3", fifo_count, 3);
        check("stall_ready", mc_if.mc_ready, 1);
        step();
        check("repr_addr", rf_address, 2);
        check("repr_data", rf_write_data, 32'h555);
        check("repr_count", fifo_count, 3);
        idle();
        for (int unsigned i = 1; i < 4; i++) begin
            step();
            check("b2b_we", rf_write_enable, 1);
            check("b2b_addr", rf_address, 10 + i);
            check("b2b_data", rf_write_data, 32'hA0 + i);
        end
        check("b2b_count", fifo_count, 0);

        // x0 filtering
        mc_push(5'd14, 32'hE);
        step();
        idle();
        check("x0_count1", fifo_count, 1);
        pipe_drive(5'd0, 32'hBAD);
        mc_push(5'd0, 32'h77);
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        step();
        idle();
        check("x0_fifo_addr", rf_address, 14);
        check("x0_fifo_data", rf_write_data, 32'hE);
        check("x0_count0", fifo_count, 0);
        check("x0_busy", busy, 0);

        // simultaneous set and clear of x9
        mc_push(5'd9, 32'h99);
        step();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        idle();
        check("sc_addr", rf_address, 9);
        check("sc_busy9", busy, 32'h0000_0200);

        // async reset with two entries queued and stall asserted
        pipe_drive(5'd3, 32'h31);
        mc_push(5'd20, 32'h20);
        step();
        mc_push(5'd21, 32'h21);
        step();
        mc_if.mc_valid = 1'b0;
        step();
        step();
        check("pre_rst_count", fifo_count, 2);
        check("pre_rst_stall", stall_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", fifo_count, 0);
        check("arst_stall", stall_req, 0);
        check("arst_we", rf_write_enable, 0);
        check("arst_addr", rf_address, 0);
        check("arst_data", rf_write_data, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", mc_if.mc_ready, 1);
        idle();
        #1;
        reset = 1'b1;
        step();
        check("post_rst_we", rf_write_enable, 0);
        check("post_rst_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
